// File: rtl/axi_llc_way_arbiter.sv
// Round-robin arbiter sharing one data-way port among the LLC units, with a read
// credit counter and a requester-index FIFO that steers way responses back home.
module axi_llc_way_arbiter #(
    parameter int unsigned NumUnits         = 4,
    parameter int unsigned MaxReadsInFlight = 4,
    parameter int unsigned InpWidth         = 8,
    parameter int unsigned OupWidth         = 8,
    parameter int unsigned WeBit            = 0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NumUnits-1:0][InpWidth-1:0]        req_i,
    input  logic [NumUnits-1:0]                      req_valid_i,
    output logic [NumUnits-1:0]                      req_ready_o,
    output logic [InpWidth-1:0]                      way_inp_o,
    output logic                                     way_inp_valid_o,
    input  logic                                     way_inp_ready_i,
    input  logic [OupWidth-1:0]                      way_out_i,
    input  logic                                     way_out_valid_i,
    output logic                                     way_out_ready_o,
    output logic [OupWidth-1:0]                      resp_o,
    output logic [NumUnits-1:0]                      resp_valid_o,
    input  logic [NumUnits-1:0]                      resp_ready_i,
    output logic [$clog2(MaxReadsInFlight+1)-1:0]    reads_in_flight_o,
    output logic                                     busy_o
);

    localparam int unsigned IdxWidth = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned PtrWidth = (MaxReadsInFlight > 1) ? $clog2(MaxReadsInFlight) : 1;
    localparam int unsigned CntWidth = $clog2(MaxReadsInFlight + 1);
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxReadsInFlight);
    localparam logic [IdxWidth-1:0] LastUnit = IdxWidth'(NumUnits - 1);
    localparam logic [PtrWidth-1:0] LastSlot = PtrWidth'(MaxReadsInFlight - 1);

    logic [IdxWidth-1:0] rr_ptr;
    logic [IdxWidth-1:0] lock_idx;
    logic                locked;
    logic [IdxWidth-1:0] grant;
    logic                any_eligible;
    logic [NumUnits-1:0] eligible;
    logic                inp_valid;
    logic                inp_hs;
    logic                grant_is_write;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [IdxWidth-1:0] head;
    logic [CntWidth-1:0] count;
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [IdxWidth-1:0] route_mem [MaxReadsInFlight];

    // Reads need a free credit from the registered count; writes never do.
    always_comb begin
        for (int i = 0; i < NumUnits; i++) begin
            eligible[i] = req_valid_i[i] & (req_i[i][WeBit] | (count < MaxCnt));
        end
    end

    // A held grant overrides the search and skips the credit check.
    always_comb begin
        logic [IdxWidth-1:0] cand;
        grant        = rr_ptr;
        any_eligible = 1'b0;
        cand         = rr_ptr;
        for (int k = 0; k < NumUnits; k++) begin
            if (!any_eligible && eligible[cand]) begin
                grant        = cand;
                any_eligible = 1'b1;
            end
            cand = (cand == LastUnit) ? '0 : cand + 1'b1;
        end
        if (locked) begin
            grant        = lock_idx;
            any_eligible = req_valid_i[lock_idx];
        end
    end

    assign inp_valid       = rst_ni & any_eligible;
    assign inp_hs          = inp_valid & way_inp_ready_i;
    assign grant_is_write  = req_i[grant][WeBit];
    assign push            = inp_hs & ~grant_is_write;
    assign way_inp_valid_o = inp_valid;
    assign way_inp_o       = inp_valid ? req_i[grant] : '0;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = inp_hs;
    end

    // The read count doubles as the routing FIFO occupancy.
    assign fifo_empty      = (count == '0);
    assign head            = route_mem[rd_ptr];
    assign way_out_ready_o = rst_ni & ~fifo_empty & resp_ready_i[head];
    assign pop             = way_out_valid_i & way_out_ready_o;
    assign resp_o          = way_out_i;

    always_comb begin
        resp_valid_o       = '0;
        resp_valid_o[head] = rst_ni & ~fifo_empty & way_out_valid_i;
    end

    assign reads_in_flight_o = count;
    assign busy_o            = (count != '0) | inp_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (inp_hs) begin
            rr_ptr <= (grant == LastUnit) ? '0 : grant + 1'b1;
            locked <= 1'b0;
        end else if (inp_valid) begin
            locked   <= 1'b1;
            lock_idx <= grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int s = 0; s < MaxReadsInFlight; s++) begin
                route_mem[s] <= '0;
            end
        end else begin
            if (push) begin
                route_mem[wr_ptr] <= grant;
                wr_ptr            <= (wr_ptr == LastSlot) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastSlot) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    resp_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
        way_out_valid_i |-> !fifo_empty);

    count_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && !pop) |-> (count < MaxCnt));

    count_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (count != '0));

    request_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (way_inp_valid_o && !way_inp_ready_i) |=> (way_inp_valid_o && $stable(way_inp_o)));

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// Bench for axi_llc_way_arbiter: directed scenarios and a random phase, every cycle
// compared against a queue-based reference model of the arbitration and routing rules.
module tb_axi_llc_way_arbiter;

    localparam int NU   = 4;
    localparam int MAXR = 4;
    localparam int IW   = 8;
    localparam int OW   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NU-1:0][IW-1:0]  req;
    logic [NU-1:0]          req_valid;
    logic [NU-1:0]          req_ready;
    logic [IW-1:0]          way_inp;
    logic                   way_inp_valid;
    logic                   way_ready;
    logic [OW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [OW-1:0]          resp;
    logic [NU-1:0]          resp_valid;
    logic [NU-1:0]          resp_ready;
    logic [2:0]             reads_in_flight;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: pointer, held grant and the queue of read owners.
    int m_ptr = 0;
    bit m_locked = 1'b0;
    int m_lock_unit = 0;
    int route_q[$];
    int last_hs_unit = -1;

    axi_llc_way_arbiter #(
        .NumUnits(NU), .MaxReadsInFlight(MAXR), .InpWidth(IW), .OupWidth(OW), .WeBit(0)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_i(req),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .way_inp_o(way_inp),
        .way_inp_valid_o(way_inp_valid),
        .way_inp_ready_i(way_ready),
        .way_out_i(out_data),
        .way_out_valid_i(out_valid),
        .way_out_ready_o(out_ready),
        .resp_o(resp),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .reads_in_flight_o(reads_in_flight),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] make_req(input bit we);
        logic [IW-1:0] p;
        p    = IW'($urandom);
        p[0] = we;
        return p;
    endfunction

    task automatic checkOutput();
        int g;
        int reads;
        int h;
        logic ev;
        logic [IW-1:0] exp_inp;
        logic [NU-1:0] exp_rr;
        logic [NU-1:0] exp_rv;
        logic exp_or;
        bit do_pop;
        g = -1;
        ev = 1'b0;
        exp_inp = '0;
        exp_rr = '0;
        exp_rv = '0;
        exp_or = 1'b0;
        do_pop = 1'b0;
        last_hs_unit = -1;
        reads = rst_n ? route_q.size() : 0;
        if (rst_n) begin
            if (m_locked) begin
                g  = m_lock_unit;
                ev = req_valid[g];
            end else begin
                for (int k = 0; k < NU; k++) begin
                    int u;
                    u = (m_ptr + k) % NU;
                    if (g < 0 && req_valid[u] && (req[u][0] || reads < MAXR)) g = u;
                end
                ev = (g >= 0);
            end
            if (ev) begin
                exp_inp = req[g];
                if (way_ready) exp_rr[g] = 1'b1;
            end
            if (reads > 0) begin
                h = route_q[0];
                exp_or = resp_ready[h];
                if (out_valid) exp_rv[h] = 1'b1;
                do_pop = out_valid && resp_ready[h];
            end
        end
        checkValue("way_inp_valid", way_inp_valid, ev);
        checkValue("way_inp", way_inp, exp_inp);
        checkValue("req_ready", req_ready, exp_rr);
        checkValue("way_out_ready", out_ready, exp_or);
        checkValue("resp_valid", resp_valid, exp_rv);
        checkValue("resp", resp, out_data);
        checkValue("reads_in_flight", reads_in_flight, reads);
        checkValue("busy", busy, (reads != 0) || ev);
        if (!rst_n) begin
            m_ptr = 0;
            m_locked = 1'b0;
            route_q.delete();
        end else begin
            if (do_pop) void'(route_q.pop_front());
            if (ev && way_ready) begin
                m_ptr = (g + 1) % NU;
                m_locked = 1'b0;
                last_hs_unit = g;
                if (!req[g][0]) route_q.push_back(g);
            end else if (ev) begin
                m_locked = 1'b1;
                m_lock_unit = g;
            end
        end
    endtask

    // One clock with the current inputs; a unit drops its request once accepted.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        if (last_hs_unit >= 0) req_valid[last_hs_unit] = 1'b0;
    endtask

    task automatic raise(input int u, input bit we);
        req[u] = make_req(we);
        req_valid[u] = 1'b1;
    endtask

    task automatic drain();
        resp_ready = '1;
        for (int i = 0; i < 40 && route_q.size() > 0; i++) begin
            out_valid = 1'b1;
            out_data = OW'($urandom);
            applyStimulus();
        end
        out_valid = 1'b0;
        #1;
        checkValue("drain_empty", reads_in_flight, 0);
    endtask

    initial begin
        logic [IW-1:0] saved;
        req = '0;
        req_valid = '0;
        way_ready = 1'b0;
        out_data = '0;
        out_valid = 1'b0;
        resp_ready = '0;

        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        $display("[TB] four reads, credit limit");
        way_ready = 1'b1;
        for (int u = 0; u < NU; u++) raise(u, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkValue("s1_count_full", reads_in_flight, 4);
        raise(0, 1'b0);
        #1;
        checkValue("s1_read_masked_ready", req_ready[0], 0);
        checkValue("s1_read_masked_valid", way_inp_valid, 0);
        out_valid = 1'b1;
        out_data = OW'($urandom);
        resp_ready = '1;
        applyStimulus();
        out_valid = 1'b0;
        #1;
        checkValue("s1_credit_next_cycle", way_inp_valid, 1);
        checkValue("s1_count_after_pop", reads_in_flight, 3);
        applyStimulus();
        checkValue("s1_count_refill", reads_in_flight, 4);
        drain();

        $display("[TB] held grant");
        way_ready = 1'b0;
        raise(2, 1'b0);
        saved = req[2];
        applyStimulus();
        raise(1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checkValue("s2_hold_payload", way_inp, saved);
            applyStimulus();
        end
        raise(0, 1'b0);
        way_ready = 1'b1;
        #1;
        checkValue("s2_hold_payload_last", way_inp, saved);
        applyStimulus();
        #1;
        checkValue("s2_next_grant_unit0", way_inp, req[0]);
        applyStimulus();
        #1;
        checkValue("s2_then_unit1", way_inp, req[1]);
        applyStimulus();
        drain();

        $display("[TB] write with credits exhausted");
        for (int u = 0; u < NU; u++) raise(u, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus();
        raise(3, 1'b1);
        #1;
        checkValue("s3_write_valid", way_inp_valid, 1);
        checkValue("s3_write_payload", way_inp, req[3]);
        checkValue("s3_write_ready", req_ready, 4'b1000);
        applyStimulus();
        checkValue("s3_count_unchanged", reads_in_flight, 4);
        drain();

        $display("[TB] response routing order");
        raise(1, 1'b0);
        applyStimulus();
        raise(0, 1'b0);
        applyStimulus();
        raise(3, 1'b0);
        applyStimulus();
        resp_ready = '1;
        out_valid = 1'b1;
        #1;
        checkValue("s4_resp_first", resp_valid, 4'b0010);
        applyStimulus();
        checkValue("s4_resp_second", resp_valid, 4'b0001);
        applyStimulus();
        checkValue("s4_resp_third", resp_valid, 4'b1000);
        applyStimulus();
        out_valid = 1'b0;
        #1;
        checkValue("s4_count_zero", reads_in_flight, 0);

        $display("[TB] response backpressure and push/pop");
        raise(1, 1'b0);
        applyStimulus();
        raise(2, 1'b0);
        applyStimulus();
        out_valid = 1'b1;
        resp_ready = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkValue("s5_out_ready_low", out_ready, 0);
            applyStimulus();
        end
        raise(0, 1'b0);
        resp_ready = '1;
        #1;
        checkValue("s5_out_ready_high", out_ready, 1);
        checkValue("s5_head_unit1", resp_valid, 4'b0010);
        applyStimulus();
        out_valid = 1'b0;
        #1;
        checkValue("s5_count_same", reads_in_flight, 2);
        drain();

        $display("[TB] reset mid-operation");
        for (int u = 0; u < 3; u++) raise(u, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkValue("s6_count_three", reads_in_flight, 3);
        raise(3, 1'b0);
        rst_n = 1'b0;
        #1;
        checkValue("s6_rst_valid", way_inp_valid, 0);
        checkValue("s6_rst_count", reads_in_flight, 0);
        checkValue("s6_rst_busy", busy, 0);
        applyStimulus();
        rst_n = 1'b1;
        req_valid = '0;
        raise(1, 1'b0);
        raise(0, 1'b0);
        #1;
        checkValue("s6_first_grant_unit0", way_inp, req[0]);
        applyStimulus();
        applyStimulus();
        drain();

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < NU; u++) begin
                if (!req_valid[u] && $urandom_range(0, 2) == 0) raise(u, 1'($urandom_range(0, 1)));
            end
            way_ready = ($urandom_range(0, 9) < 7);
            resp_ready = NU'($urandom);
            out_valid = (route_q.size() > 0) && ($urandom_range(0, 1) == 1);
            out_data = OW'($urandom);
            applyStimulus();
        end
        for (int i = 0; i < 100 && (req_valid != '0 || route_q.size() > 0); i++) begin
            way_ready = 1'b1;
            resp_ready = '1;
            out_valid = (route_q.size() > 0);
            out_data = OW'($urandom);
            applyStimulus();
        end
        out_valid = 1'b0;
        #1;
        checkValue("final_idle_valid", way_inp_valid, 0);
        checkValue("final_idle_count", reads_in_flight, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
